// File: rtl/sweep_ctrl_if.sv
// Host/counter-facing signal bundle for sweep_ctrl.
// Latency: none; wiring only.
// Backpressure: none; stop is the only way to halt a running sweep.
interface sweep_ctrl_if #(
  parameter int SIZE  = 8,
  parameter int CYC_W = 8
);
  logic             start;
  logic             stop;
  logic [SIZE-1:0]  lo;
  logic [SIZE-1:0]  hi;
  logic [CYC_W-1:0] cycles;
  logic [SIZE-1:0]  count_in;
  logic             cnt_enable;
  logic             cnt_up_down;
  logic [SIZE-1:0]  cnt_load;
  logic             busy;
  logic             done;
  logic             err;

  // Host side plus the counter's count feedback.
  modport master (
    output start, stop, lo, hi, cycles, count_in,
    input  cnt_enable, cnt_up_down, cnt_load, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  start, stop, lo, hi, cycles, count_in,
    output cnt_enable, cnt_up_down, cnt_load, busy, done, err
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Sequencer driving an up/down counter through a triangular sweep lo..hi; optional bound dwell via SWEEP_CTRL_DWELL_EN.
// Latency: start sampled at edge k -> LOAD in cycle k+1; cnt_* are Mealy on state/count_in; busy/done/err registered.
// Backpressure: none; stop or an out-of-range count aborts to IDLE with cnt_enable forced low that cycle.
module sweep_ctrl #(
  parameter int SIZE  = 8,
  parameter int CYC_W = 8
`ifdef SWEEP_CTRL_DWELL_EN
  , parameter int DWELL = 4
`endif
) (
  input logic         clk,
  input logic         reset,
  sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN
`ifdef SWEEP_CTRL_DWELL_EN
    , HOLD_HI,
    HOLD_LO
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  lo_q, lo_d;
  logic [SIZE-1:0]  hi_q, hi_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] sweep_q, sweep_d;
  logic [CYC_W-1:0] sweep_inc;
  logic             busy_q, done_q, err_q;
  logic             done_set, err_set;
  logic             first_q;
  logic             excursion;
  logic             cnt_enable, cnt_up_down;
  logic [SIZE-1:0]  cnt_load;

`ifdef SWEEP_CTRL_DWELL_EN
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  logic [DW_W-1:0] dwell_q, dwell_d;
`endif

  // Next-state and Mealy counter controls; the counter output is checked in the same cycle so bounds are never overshot.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cyc_d       = cyc_q;
    sweep_d     = sweep_q;
    done_set    = 1'b0;
    err_set     = 1'b0;
    cnt_enable  = 1'b0;
    cnt_up_down = 1'b0;
    cnt_load    = '0;
    sweep_inc   = sweep_q + CYC_W'(1);
    // The first UP cycle after LOAD is exempt: the count may not reflect the load yet.
    excursion   = !first_q && ((bus.count_in > hi_q) || (bus.count_in < lo_q));
`ifdef SWEEP_CTRL_DWELL_EN
    dwell_d     = dwell_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          // lo of zero would read as "no load" at the counter.
          if ((bus.lo != '0) && (bus.lo < bus.hi)) begin
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            cyc_d   = bus.cycles;
            sweep_d = '0;
            state_d = LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          cnt_enable  = 1'b1;
          cnt_load    = lo_q;
          cnt_up_down = 1'b1;
          state_d     = UP;
        end
      end
      UP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (excursion) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (bus.count_in == hi_q) begin
`ifdef SWEEP_CTRL_DWELL_EN
          dwell_d = DW_W'(DWELL - 1);
          state_d = HOLD_HI;
`else
          cnt_enable  = 1'b1;
          cnt_up_down = 1'b0;
          state_d     = DOWN;
`endif
        end else begin
          cnt_enable  = 1'b1;
          cnt_up_down = 1'b1;
        end
      end
      DOWN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (excursion) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (bus.count_in == lo_q) begin
          // Termination is decided on arrival at lo, so the last lo gets no dwell.
          sweep_d = sweep_inc;
          if ((cyc_q != '0) && (sweep_inc == cyc_q)) begin
            done_set = 1'b1;
            state_d  = IDLE;
          end else begin
`ifdef SWEEP_CTRL_DWELL_EN
            dwell_d = DW_W'(DWELL - 1);
            state_d = HOLD_LO;
`else
            cnt_enable  = 1'b1;
            cnt_up_down = 1'b1;
            state_d     = UP;
`endif
          end
        end else begin
          cnt_enable  = 1'b1;
          cnt_up_down = 1'b0;
        end
      end
`ifdef SWEEP_CTRL_DWELL_EN
      // The bound cycle itself is the first dwell cycle; the last hold cycle performs the turnaround step.
      HOLD_HI: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (dwell_q == '0) begin
          cnt_enable  = 1'b1;
          cnt_up_down = 1'b0;
          state_d     = DOWN;
        end else begin
          dwell_d = dwell_q - DW_W'(1);
        end
      end
      HOLD_LO: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (dwell_q == '0) begin
          cnt_enable  = 1'b1;
          cnt_up_down = 1'b1;
          state_d     = UP;
        end else begin
          dwell_d = dwell_q - DW_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, latched bounds, sweep counter and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      cyc_q   <= '0;
      sweep_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cyc_q   <= cyc_d;
      sweep_q <= sweep_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_set;
      err_q   <= err_set;
      first_q <= (state_q == LOAD);
`ifdef SWEEP_CTRL_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign bus.cnt_enable  = cnt_enable;
  assign bus.cnt_up_down = cnt_up_down;
  assign bus.cnt_load    = cnt_load;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
